// File: rtl/avr_io_pkg.sv
// avr_io_pkg: shared addresses, clock-select codes, bit positions and divisor table for the AVR timer0 block.
package avr_io_pkg;
  localparam logic [5:0] DEF_ADDR_TCNT  = 6'h32;
  localparam logic [5:0] DEF_ADDR_TCCR  = 6'h33;
  localparam logic [5:0] DEF_ADDR_TIFR  = 6'h38;
  localparam logic [5:0] DEF_ADDR_TIMSK = 6'h39;
  localparam logic [5:0] DEF_ADDR_OCR   = 6'h3C;
  localparam logic [2:0] CS_STOP    = 3'd0;
  localparam logic [2:0] CS_DIV1    = 3'd1;
  localparam logic [2:0] CS_DIV8    = 3'd2;
  localparam logic [2:0] CS_DIV64   = 3'd3;
  localparam logic [2:0] CS_DIV256  = 3'd4;
  localparam logic [2:0] CS_DIV1024 = 3'd5;
  localparam int TOV_BIT = 0;
  localparam int OCF_BIT = 1;
  localparam int CTC_BIT = 3;
  // Divisor per clock-select code; 0 means the timer is stopped.
  function automatic logic [10:0] cs_divisor(input logic [2:0] cs);
    case (cs)
      CS_DIV1:    return 11'd1;
      CS_DIV8:    return 11'd8;
      CS_DIV64:   return 11'd64;
      CS_DIV256:  return 11'd256;
      CS_DIV1024: return 11'd1024;
      default:    return 11'd0;
    endcase
  endfunction
endpackage

// File: rtl/avr_timer_prescaler.sv
// avr_timer_prescaler: 10-bit prescaler producing a one-cycle tick every cs-selected divisor cycles.
// Ports: clk, rst (async active-low), cs (clock select), clear (restart count), tick (one-cycle pulse).
module avr_timer_prescaler
  import avr_io_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cs,
  input  logic       clear,
  output logic       tick
);
  logic [9:0] cnt;
  logic [10:0] div;
  logic run;
  assign div  = cs_divisor(cs);
  assign run  = |div;
  assign tick = run && ({1'b0, cnt} == div - 11'd1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else cnt <= (clear || !run || tick) ? '0 : cnt + 10'd1;
  end
endmodule

// File: rtl/avr_io_timer0.sv
// avr_io_timer0: AVR-style 8-bit timer/counter 0 with compare, CTC mode and overflow/compare interrupts on the CPU I/O bus.
// Ports: clk, rst (async active-low), io_addr/io_read/io_write/io_wdata (CPU I/O bus),
//        io_rdata/io_hit (combinational read return), irq (OR of enabled flags).
module avr_io_timer0
  import avr_io_pkg::*;
#(
  parameter logic [5:0] ADDR_TCNT  = DEF_ADDR_TCNT,
  parameter logic [5:0] ADDR_TCCR  = DEF_ADDR_TCCR,
  parameter logic [5:0] ADDR_TIFR  = DEF_ADDR_TIFR,
  parameter logic [5:0] ADDR_TIMSK = DEF_ADDR_TIMSK,
  parameter logic [5:0] ADDR_OCR   = DEF_ADDR_OCR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] io_addr,
  input  logic       io_read,
  input  logic       io_write,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic       io_hit,
  output logic       irq
);
  logic [7:0] tcnt, ocr;
  logic [3:0] tccr;
  logic [1:0] tifr, timsk, hw_set;
  logic wr_tcnt, wr_tccr, wr_tifr, wr_timsk, wr_ocr;
  logic tick, ctc, match, ovf, any_addr;
  assign wr_tcnt  = io_write && io_addr == ADDR_TCNT;
  assign wr_tccr  = io_write && io_addr == ADDR_TCCR;
  assign wr_tifr  = io_write && io_addr == ADDR_TIFR;
  assign wr_timsk = io_write && io_addr == ADDR_TIMSK;
  assign wr_ocr   = io_write && io_addr == ADDR_OCR;
  assign ctc = tccr[CTC_BIT];
  avr_timer_prescaler u_pre (
    .clk  (clk),
    .rst  (rst),
    .cs   (tccr[2:0]),
    .clear(wr_tccr),
    .tick (tick)
  );
  // A CPU write to TCNT overrides the tick, so neither event may fire that cycle.
  assign match = tick && !wr_tcnt && tcnt == ocr;
  assign ovf   = tick && !wr_tcnt && !ctc && tcnt == 8'hFF;
  always_comb begin
    hw_set = 2'b00;
    hw_set[TOV_BIT] = ovf;
    hw_set[OCF_BIT] = match;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt  <= '0;
      tccr  <= '0;
      ocr   <= '0;
      tifr  <= '0;
      timsk <= '0;
    end else begin
      tcnt <= wr_tcnt ? io_wdata : !tick ? tcnt : (ctc && match) ? 8'h00 : tcnt + 8'd1;
      if (wr_tccr) tccr <= io_wdata[3:0];
      if (wr_ocr) ocr <= io_wdata;
      if (wr_timsk) timsk <= io_wdata[1:0];
      // Clear first, then OR in hardware sets so a same-cycle set wins.
      tifr <= (tifr & ~(wr_tifr ? io_wdata[1:0] : 2'b00)) | hw_set;
    end
  end
  assign any_addr = io_addr == ADDR_TCNT || io_addr == ADDR_TCCR || io_addr == ADDR_TIFR ||
                    io_addr == ADDR_TIMSK || io_addr == ADDR_OCR;
  assign io_hit = io_read && any_addr;
  assign io_rdata = !io_hit ? 8'h00 :
                    io_addr == ADDR_TCNT  ? tcnt :
                    io_addr == ADDR_TCCR  ? {4'h0, tccr} :
                    io_addr == ADDR_TIFR  ? {6'h00, tifr} :
                    io_addr == ADDR_TIMSK ? {6'h00, timsk} : ocr;
  assign irq = |(tifr & timsk);
endmodule

// File: tb/tb_avr_io_timer0.sv
// tb_avr_io_timer0: directed self-checking bench for avr_io_timer0.
module tb_avr_io_timer0;
  localparam logic [5:0] A_TCNT = 6'h32, A_TCCR = 6'h33, A_TIFR = 6'h38, A_TIMSK = 6'h39, A_OCR = 6'h3C;
  logic clk = 1'b0, rst = 1'b0, io_read = 1'b0, io_write = 1'b0, io_hit, irq;
  logic [5:0] io_addr = '0;
  logic [7:0] io_wdata = '0, io_rdata;
  int errors = 0, checks = 0;
  avr_io_timer0 dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_read(io_read), .io_write(io_write),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_hit(io_hit), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    io_addr = a;
    io_wdata = d;
    io_write = 1'b1;
    @(posedge clk);
    #1;
    io_write = 1'b0;
    io_addr = '0;
  endtask
  task automatic rd(input string tag, input logic [5:0] a, input logic [7:0] exp);
    io_addr = a;
    io_read = 1'b1;
    #1;
    check(tag, io_rdata, exp);
    io_read = 1'b0;
    io_addr = '0;
  endtask
  initial begin
    #1;
    rd("rst_tcnt", A_TCNT, 8'h00);
    check("rst_irq", irq, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1);
    wr(A_OCR, 8'hC0);
    wr(A_TCCR, 8'h01);
    cyc(10);
    rd("run_tcnt", A_TCNT, 8'h0A);
    rd("run_tifr", A_TIFR, 8'h00);
    io_addr = A_TCCR; io_read = 1'b1; #1;
    check("hit_valid", io_hit, 8'h01);
    io_read = 1'b0; #1;
    check("no_read_rdata", io_rdata, 8'h00);
    wr(A_TCCR, 8'h00);
    wr(A_TCNT, 8'hFE);
    wr(A_TIMSK, 8'h01);
    wr(A_TIFR, 8'h03);
    wr(A_TCCR, 8'h01);
    cyc(2);
    rd("ovf_tcnt", A_TCNT, 8'h00);
    rd("ovf_tifr", A_TIFR, 8'h01);
    check("ovf_irq", irq, 8'h01);
    wr(A_TIFR, 8'h01);
    rd("w1c_tifr", A_TIFR, 8'h00);
    check("w1c_irq", irq, 8'h00);
    wr(A_TCCR, 8'h00);
    wr(A_TCNT, 8'h00);
    wr(A_OCR, 8'h03);
    wr(A_TIFR, 8'h03);
    wr(A_TIMSK, 8'h00);
    wr(A_TCCR, 8'h0A);
    cyc(7);
    rd("ctc_t7", A_TCNT, 8'h00);
    cyc(1);
    rd("ctc_t8", A_TCNT, 8'h01);
    cyc(8);
    rd("ctc_t16", A_TCNT, 8'h02);
    cyc(8);
    rd("ctc_t24", A_TCNT, 8'h03);
    rd("ctc_tifr24", A_TIFR, 8'h00);
    cyc(8);
    rd("ctc_t32", A_TCNT, 8'h00);
    rd("ctc_tifr32", A_TIFR, 8'h02);
    wr(A_TCCR, 8'h00);
    wr(A_TIFR, 8'h03);
    wr(A_OCR, 8'h10);
    wr(A_TCNT, 8'h10);
    wr(A_TCCR, 8'h01);
    wr(A_TCNT, 8'h80);
    rd("wr_tick_tcnt", A_TCNT, 8'h80);
    rd("wr_tick_tifr", A_TIFR, 8'h00);
    wr(A_OCR, 8'h81);
    wr(A_TIFR, 8'h02);
    rd("set_wins_tifr", A_TIFR, 8'h02);
    rd("set_wins_tcnt", A_TCNT, 8'h82);
    wr(A_TIFR, 8'h02);
    rd("clr_ocf_tifr", A_TIFR, 8'h00);
    wr(A_TIFR, 8'h00);
    wr(A_TCCR, 8'h00);
    wr(A_OCR, 8'hFF);
    wr(A_TCNT, 8'hFF);
    wr(A_TIMSK, 8'h03);
    wr(A_TCCR, 8'h01);
    cyc(1);
    rd("both_tifr", A_TIFR, 8'h03);
    wr(A_TCCR, 8'h05);
    wr(A_TCNT, 8'h40);
    rd("pre_rst_tcnt", A_TCNT, 8'h40);
    rd("pre_rst_tccr", A_TCCR, 8'h05);
    check("pre_rst_irq", irq, 8'h01);
    #1;
    rst = 1'b0;
    #1;
    check("arst_irq", irq, 8'h00);
    check("arst_rdata", io_rdata, 8'h00);
    rd("arst_tcnt", A_TCNT, 8'h00);
    rd("arst_tccr", A_TCCR, 8'h00);
    rd("arst_tifr", A_TIFR, 8'h00);
    rd("arst_timsk", A_TIMSK, 8'h00);
    rd("arst_ocr", A_OCR, 8'h00);
    cyc(1);
    rst = 1'b1;
    cyc(2000);
    rd("post_rst_tcnt", A_TCNT, 8'h00);
    wr(A_OCR, 8'h5A);
    io_addr = 6'h20; io_read = 1'b1; #1;
    check("bad_hit", io_hit, 8'h00);
    check("bad_rdata", io_rdata, 8'h00);
    io_read = 1'b0;
    wr(6'h20, 8'hFF);
    rd("bad_wr_ocr", A_OCR, 8'h5A);
    rd("bad_wr_tcnt", A_TCNT, 8'h00);
    rd("bad_wr_tccr", A_TCCR, 8'h00);
    rd("bad_wr_timsk", A_TIMSK, 8'h00);
    rd("bad_wr_tifr", A_TIFR, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/avr_io_timer0.md
AVR_IO_TIMER0 -- requirements
Module: avr_io_timer0

Interface
REQ-001 Parameter ADDR_TCNT, default 6'h32, I/O address of the counter register TCNT0.
REQ-002 Parameter ADDR_TCCR, default 6'h33, I/O address of the control register TCCR0.
REQ-003 Parameter ADDR_TIFR, default 6'h38, I/O address of the flag register TIFR.
REQ-004 Parameter ADDR_TIMSK, default 6'h39, I/O address of the interrupt mask register TIMSK.
REQ-005 Parameter ADDR_OCR, default 6'h3C, I/O address of the compare register OCR0.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 io_addr  input  6  CPU I/O address.
REQ-009 io_read  input  1  CPU read strobe, one cycle.
REQ-010 io_write  input  1  CPU write strobe, one cycle.
REQ-011 io_wdata  input  8  CPU write data (the CPU's io_out).
REQ-012 io_rdata  output  8  read data for the CPU's io_in mux.
REQ-013 io_hit  output  1  high when io_read is high and io_addr matches any register of this block.
REQ-014 irq  output  1  timer interrupt request.

Function
REQ-015 Read path is combinational: io_rdata is the addressed register when io_hit is high, else 8'h00. Unused TCCR/TIFR/TIMSK bits read 0.
REQ-016 Writes take effect at the clock edge on which io_write is high with a matching address.
REQ-017 TCCR0 bits: CS = [2:0], CTC = [3]. TIFR and TIMSK bits: TOV = [0], OCF = [1].
REQ-018 CS encodes the tick divisor: 0 = stopped, 1 = /1, 2 = /8, 3 = /64, 4 = /256, 5 = /1024, 6 and 7 = stopped.
REQ-019 The prescaler is a 10-bit counter.
- It produces a one-cycle tick when it equals divisor-1 and then returns to 0.
- It is held at 0 while the timer is stopped.
- It is cleared on any TCCR write.
REQ-020 In normal mode (CTC = 0), TCNT increments by 1 on each tick.
- The 8'hFF to 8'h00 transition sets TOV.
REQ-021 A compare match occurs on a tick with TCNT == OCR before the increment, and sets OCF.
- In CTC mode, TCNT loads 8'h00 instead of incrementing.
- In CTC mode, TOV is never set.
REQ-022 CPU write to TCNT in the same cycle as a tick: the written value wins, and compare match and TOV are suppressed for that cycle.
REQ-023 TIFR is write-1-to-clear; written 0 bits have no effect.
- A hardware set and a CPU clear of the same bit in the same cycle: set wins.
REQ-024 OCR and TIMSK are plain read/write registers.
- A new OCR value is used for comparison from the cycle after the write.
REQ-025 irq = OR over (TIFR & TIMSK), driven combinationally from registers.
REQ-026 Reads have no side effects.
REQ-027 Non-matching addresses are ignored for both read and write.

Reset
REQ-028 On rst low, all of the following clear to 0 immediately, independent of clk: TCNT, TCCR, OCR, TIFR, TIMSK and the prescaler.
- irq = 0; io_rdata = 0 when no read is in progress.
REQ-029 A count in progress when reset is asserted is discarded.
- The first tick after release occurs only after CS is written.

Structure
REQ-030 Shared package avr_io_pkg holds:
- the five default addresses;
- the CS encodings;
- the TOV/OCF/CTC bit positions;
- the divisor table.
REQ-031 Sub-module avr_timer_prescaler: inputs cs, clear; output tick. It holds the 10-bit prescaler counter.

Verification
REQ-032 Write TCCR = 8'h01, read TCNT after 10 cycles -> TCNT = 8'h0A (±1 for write latency); TIFR = 0.
REQ-033 CS = 1, TCNT preset 8'hFE, TIMSK = 8'h01 -> two ticks later TCNT = 8'h00, TOV = 1, irq = 1. Then write TIFR = 8'h01 -> TOV = 0, irq = 0.
REQ-034 CS = 2 (/8), CTC = 1, OCR = 8'h03 -> TCNT sequence 0,1,2,3,0 with one tick every 8 cycles; OCF set on the 3->0 tick; TOV stays 0.
REQ-035 Write TCNT = 8'h80 on the same cycle as a tick with TCNT = OCR -> TCNT = 8'h80 and OCF not set. Also: OCF set and TIFR = 8'h02 written in the same cycle -> OCF remains 1.
REQ-036 Assert rst mid-count (CS = 5, TCNT = 8'h40, TIFR = 8'h03) -> all registers read 0 and irq = 0 immediately. After release, TCNT stays 0 for 2000 cycles.
REQ-037 io_read to address 6'h20 -> io_hit = 0, io_rdata = 8'h00. Write to 6'h20 -> no register changes.
